// File: rtl/prog_loader.sv
// prog_loader: boot loader that parses a length-prefixed, big-endian byte stream,
// writes each 32-bit word into instruction memory and then releases the CPU.
module prog_loader #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_run,
   output logic              err,
   output logic [15:0]       words_loaded
);

   localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [63:0] DEPTH  = 64'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_CNT_HI = 3'd0,
      S_CNT_LO = 3'd1,
      S_WORD   = 3'd2,
      S_WRITE  = 3'd3,
      S_RUN    = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_byte_ready;
   logic                r_im_we;
   logic                r_cpu_run;
   logic                r_err;
   logic [ADDR_W-1:0]   r_im_addr;
   logic [31:0]         r_im_wdata;
   logic [15:0]         r_words;
   logic [15:0]         r_count;
   logic [23:0]         r_word;
   logic [1:0]          r_pos;
   logic [IDLE_W-1:0]   r_idle;

   logic                w_accept;
   logic                w_idle_st;
   logic                w_timeout;
   logic                w_last;
   logic [15:0]         w_count;
   logic                w_byte_ready_nxt;
   logic                w_we_nxt;
   logic                w_run_nxt;
   logic                w_err_nxt;

   assign w_accept  = byte_valid & r_byte_ready;
   assign w_count   = {r_count[15:8], byte_data};
   assign w_idle_st = (r_state == S_CNT_LO) || (r_state == S_WORD);
   assign w_timeout = w_idle_st && !w_accept &&
                      ((32'(r_idle) + 32'd1) >= 32'(TIMEOUT));
   assign w_last    = ((r_words + 16'd1) == r_count);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_CNT_HI;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CNT_HI: begin
            if (w_accept) w_state_nxt = S_CNT_LO;
         end
         S_CNT_LO: begin
            if (w_accept) begin
               if (w_count == 16'd0)             w_state_nxt = S_RUN;
               else if (64'(w_count) > DEPTH)    w_state_nxt = S_ERR;
               else                              w_state_nxt = S_WORD;
            end else if (w_timeout) begin
               w_state_nxt = S_ERR;
            end
         end
         S_WORD: begin
            if (w_accept && (r_pos == 2'd3)) w_state_nxt = S_WRITE;
            else if (w_timeout)              w_state_nxt = S_ERR;
         end
         S_WRITE: w_state_nxt = w_last ? S_RUN : S_WORD;
         S_RUN:   w_state_nxt = S_RUN;
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_ERR;
      endcase
   end

   // Output decode from the upcoming state so the registered outputs track it
   always_comb begin
      w_byte_ready_nxt = 1'b0;
      w_we_nxt         = 1'b0;
      w_run_nxt        = 1'b0;
      w_err_nxt        = 1'b0;
      case (w_state_nxt)
         S_CNT_HI, S_CNT_LO, S_WORD: w_byte_ready_nxt = 1'b1;
         S_WRITE:                    w_we_nxt         = 1'b1;
         S_RUN:                      w_run_nxt        = 1'b1;
         S_ERR:                      w_err_nxt        = 1'b1;
         default:                    w_err_nxt        = 1'b1;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_ready <= 1'b1;
         r_im_we      <= 1'b0;
         r_cpu_run    <= 1'b0;
         r_err        <= 1'b0;
         r_im_addr    <= '0;
         r_im_wdata   <= '0;
         r_words      <= '0;
         r_count      <= '0;
         r_word       <= '0;
         r_pos        <= '0;
         r_idle       <= '0;
      end else begin
         r_byte_ready <= w_byte_ready_nxt;
         r_im_we      <= w_we_nxt;
         r_cpu_run    <= w_run_nxt;
         r_err        <= w_err_nxt;

         if (w_accept && (r_state == S_CNT_HI)) r_count[15:8] <= byte_data;
         if (w_accept && (r_state == S_CNT_LO)) r_count[7:0]  <= byte_data;

         if (w_accept && (r_state == S_WORD)) begin
            r_word <= {r_word[15:0], byte_data};
            r_pos  <= r_pos + 2'd1;
         end

         // Idle counter only runs while waiting for frame bytes
         if (w_idle_st) begin
            if (w_accept)        r_idle <= '0;
            else if (!w_timeout) r_idle <= r_idle + IDLE_W'(1);
         end else begin
            r_idle <= '0;
         end

         // Address and data are captured on entry so they are valid during WRITE
         if ((r_state == S_WORD) && (w_state_nxt == S_WRITE)) begin
            r_im_addr  <= ADDR_W'(r_words);
            r_im_wdata <= {r_word, byte_data};
         end

         if (r_state == S_WRITE) r_words <= r_words + 16'd1;
      end
   end

   assign byte_ready   = r_byte_ready;
   assign im_we        = r_im_we;
   assign im_addr      = r_im_addr;
   assign im_wdata     = r_im_wdata;
   assign cpu_run      = r_cpu_run;
   assign err          = r_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives directed and random frames with random gaps and compares
// the loader against a frame-level model of accepted bytes, writes and outcome.
module tb_prog_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int          TMO    = 40;
   localparam int          DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_run;
   logic              err;
   logic [15:0]       words_loaded;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_run      (cpu_run),
      .err          (err),
      .words_loaded (words_loaded)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/edge monitor, sampled on the falling edge
   logic [ADDR_W+31:0] wq[$];
   int   run_rise = -1;
   int   err_rise = -1;
   logic prev_run = 1'b0;
   logic prev_err = 1'b0;

   always @(negedge clk) begin
      if (im_we === 1'b1) wq.push_back({im_addr, im_wdata});
      if (cpu_run === 1'b1 && prev_run !== 1'b1) run_rise = cyc;
      if (err === 1'b1 && prev_err !== 1'b1) err_rise = cyc;
      prev_run = cpu_run;
      prev_err = err;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Frame under test: bytes and idle cycles before each byte
   logic [7:0] fb[$];
   int         fg[$];

   // Reference model results
   int          m_acc;
   bit          m_run;
   bit          m_err;
   bit          m_timeout;
   bit          m_wend;
   logic [15:0] m_n;
   logic [31:0] mw[$];

   // Idle cycles directly after a word's last byte include one non-waiting write cycle
   function automatic void model();
      bit wend;
      int eff;
      m_acc = 0; m_run = 0; m_err = 0; m_timeout = 0; m_wend = 0; m_n = 16'd0;
      mw.delete();
      for (int i = 0; i < fb.size(); i++) begin
         if (m_run || m_err) break;
         if (i > 0) begin
            wend = (i - 1 >= 2) && (((i - 3) % 4) == 3);
            eff  = fg[i] - (wend ? 1 : 0);
            if (eff < 0) eff = 0;
            if (eff >= TMO) begin
               m_err = 1; m_timeout = 1; m_wend = wend;
               break;
            end
         end
         m_acc++;
         if (i == 1) begin
            m_n = {fb[0], fb[1]};
            if (m_n == 16'd0)      m_run = 1;
            else if (m_n > DEPTH)  m_err = 1;
         end else if (i >= 2 && ((i - 2) % 4) == 3) begin
            mw.push_back({fb[i-3], fb[i-2], fb[i-1], fb[i]});
            if (mw.size() == int'(m_n)) m_run = 1;
         end
      end
   endfunction

   task automatic do_reset(input int n);
      @(negedge clk);
      rst        = 1'b1;
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap, output bit ok);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
      end
      ok = 1'b0;
      for (int t = 0; t < 6 && !ok; t++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = b;
         ok         = (byte_ready === 1'b1);
      end
   endtask

   task automatic zero_gaps();
      fg.delete();
      for (int i = 0; i < fb.size(); i++) fg.push_back(0);
   endtask

   task automatic build_frame(input int n, input int mode);
      fb.delete();
      fb.push_back(8'(n >> 8));
      fb.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
      fb.push_back(8'hA5);
      fb.push_back(8'h5A);
      fg.delete();
      for (int i = 0; i < fb.size(); i++) begin
         if (mode == 0)                                    fg.push_back(0);
         else if (mode == 1)                               fg.push_back(int'($urandom_range(0, 1)));
         else if ($urandom_range(0, 11) == 0 && i > 0)     fg.push_back(TMO - 1 + int'($urandom_range(0, 2)));
         else                                              fg.push_back(int'($urandom_range(0, 3)));
      end
   endtask

   task automatic run_frame(input bit do_rst);
      bit ok;
      int acc, last_acc, wbase, start, got_run, got_err, exp_run, exp_err;
      if (do_rst) do_reset(2);
      start    = cyc;
      wbase    = wq.size();
      acc      = 0;
      last_acc = 0;
      for (int i = 0; i < fb.size(); i++) begin
         send(fb[i], fg[i], ok);
         if (!ok) break;
         acc++;
         last_acc = cyc + 1;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (4) @(negedge clk);
      model();
      chk_eq("accepted", 64'(acc), 64'(m_acc));
      chk_eq("n_writes", 64'(wq.size() - wbase), 64'(mw.size()));
      for (int k = 0; k < mw.size() && wbase + k < wq.size(); k++)
         chk_eq("write", 64'(wq[wbase+k]), 64'({ADDR_W'(k), mw[k]}));
      chk_eq("cpu_run", 64'(cpu_run), 64'(m_run));
      chk_eq("err", 64'(err), 64'(m_err));
      chk_eq("byte_ready", 64'(byte_ready), 64'(!(m_run || m_err)));
      chk_eq("words_loaded", 64'(words_loaded), 64'(mw.size()));
      chk_eq("im_we_idle", 64'(im_we), 64'(0));
      got_run = (run_rise > start) ? run_rise : -1;
      got_err = (err_rise > start) ? err_rise : -1;
      exp_run = m_run ? last_acc + ((m_n == 16'd0) ? 0 : 1) : -1;
      exp_err = m_err ? (m_timeout ? last_acc + TMO + int'(m_wend) : last_acc) : -1;
      chk_eq("run_cycle", 64'(got_run), 64'(exp_run));
      chk_eq("err_cycle", 64'(got_err), 64'(exp_err));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int base;
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;

      // Reset state
      do_reset(2);
      chk_eq("rst_byte_ready", 64'(byte_ready), 64'(1));
      chk_eq("rst_im_we", 64'(im_we), 64'(0));
      chk_eq("rst_cpu_run", 64'(cpu_run), 64'(0));
      chk_eq("rst_err", 64'(err), 64'(0));
      chk_eq("rst_words", 64'(words_loaded), 64'(0));
      chk_eq("rst_im_addr", 64'(im_addr), 64'(0));
      chk_eq("rst_im_wdata", 64'(im_wdata), 64'(0));
      chk_eq("rst_no_write", 64'(wq.size()), 64'(0));

      // Two-word program back-to-back
      fb = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'hAA, 8'h55};
      zero_gaps();
      run_frame(1);

      // Empty program
      fb = '{8'h00, 8'h00, 8'hAA, 8'h55};
      zero_gaps();
      run_frame(1);

      // Oversize count, trailing bytes must be refused
      fb = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
      zero_gaps();
      run_frame(1);

      // Largest legal program fills the whole memory
      build_frame(DEPTH, 1);
      run_frame(1);

      // Stalls well below the timeout
      fb = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA};
      fg.delete();
      for (int i = 0; i < fb.size(); i++) fg.push_back(5);
      run_frame(1);

      // Timeout boundaries inside a word, after a word end and in the count
      fb = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};
      zero_gaps(); fg[4] = TMO;     run_frame(1);
      zero_gaps(); fg[4] = TMO - 1; run_frame(1);
      zero_gaps(); fg[6] = TMO;     run_frame(1);
      zero_gaps(); fg[6] = TMO + 1; run_frame(1);
      zero_gaps(); fg[1] = TMO;     run_frame(1);
      zero_gaps(); fg[1] = TMO - 1; run_frame(1);

      // Reset after five bytes of a two-word frame, then resend
      fb = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA};
      zero_gaps();
      do_reset(2);
      base = wq.size();
      for (int i = 0; i < 5; i++) send(fb[i], 0, ok);
      do_reset(1);
      chk_eq("mid_rst_ready", 64'(byte_ready), 64'(1));
      chk_eq("mid_rst_words", 64'(words_loaded), 64'(0));
      chk_eq("mid_rst_run", 64'(cpu_run), 64'(0));
      chk_eq("mid_rst_err", 64'(err), 64'(0));
      @(negedge clk);
      chk_eq("mid_rst_no_write", 64'(wq.size() - base), 64'(0));
      run_frame(0);

      // Reset on the same edge as the byte that completes a word
      do_reset(2);
      base = wq.size();
      for (int i = 0; i < 6; i++) send(fb[i], 0, ok);
      rst = 1'b1;
      @(negedge clk);
      chk_eq("coll_rst_im_we", 64'(im_we), 64'(0));
      chk_eq("coll_rst_ready", 64'(byte_ready), 64'(1));
      rst        = 1'b0;
      byte_valid = 1'b0;
      @(negedge clk);
      chk_eq("coll_post_im_we", 64'(im_we), 64'(0));
      chk_eq("coll_no_write", 64'(wq.size() - base), 64'(0));
      chk_eq("coll_words", 64'(words_loaded), 64'(0));
      run_frame(0);

      // Random frames including zero, oversize and near-timeout gaps
      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(0, 9))
            0:       build_frame(0, 2);
            1:       build_frame(DEPTH + int'($urandom_range(1, 3)), 0);
            default: build_frame(int'($urandom_range(1, 6)), 2);
         endcase
         if (fb.size() > 40) begin
            fb = fb[0:5];
            zero_gaps();
         end
         run_frame(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the maximum number of idle cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port byte_valid, input, 1 bit: upstream byte present.
REQ-006 SHALL have port byte_data, input, 8 bits: upstream byte.
REQ-007 SHALL have port byte_ready, output, 1 bit: loader accepts the byte this cycle.
REQ-008 SHALL have port im_we, output, 1 bit: instruction-memory write strobe.
REQ-009 SHALL have port im_addr, output, ADDR_W bits: instruction-memory word address.
REQ-010 SHALL have port im_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port cpu_run, output, 1 bit: releases the CPU (PC held at 0 while low).
REQ-012 SHALL have port err, output, 1 bit: frame error, sticky.
REQ-013 SHALL have port words_loaded, output, 16 bits: number of words written so far.

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both 1.
REQ-015 SHALL parse frame format: 2-byte word count N (big-endian), then N words of 4 bytes each, big-endian (first byte goes to im_wdata[31:24]).
REQ-016 SHALL implement states CNT_HI, CNT_LO, WORD, WRITE, RUN, ERR.
- byte_ready = 1 in CNT_HI, CNT_LO and WORD; 0 in WRITE, RUN and ERR.
REQ-017 SHALL handle CNT_HI -> CNT_LO on an accepted byte; CNT_HI waits indefinitely with no timeout.
REQ-018 SHALL handle CNT_LO -> RUN if N==0; -> ERR if N > 2^ADDR_W; else -> WORD.
REQ-019 SHALL handle WORD: on accepting the 4th byte of a word, -> WRITE on the next cycle.
REQ-020 SHALL handle WRITE: im_we=1 for exactly one cycle, with im_addr = word index (starting at 0) and im_wdata = the assembled word.
- Index and words_loaded increment at the end of that cycle.
- Next state is RUN if this was word N-1, else WORD.
REQ-021 SHALL drive im_we=0 in all states except WRITE; im_addr and im_wdata hold their last values when not writing.
REQ-022 SHALL make cpu_run a registered output: 1 from the first cycle in RUN onward, and 0 in every other state.
REQ-023 SHALL make RUN and ERR terminal; leave them only via rst.
REQ-024 SHALL apply a timeout in CNT_LO and WORD:
- An idle counter clears on each accepted byte and increments on every other cycle.
- Reaching TIMEOUT -> ERR.
- The counter does not run in other states.
REQ-025 SHALL make err=1 from the first cycle in ERR onward, with cpu_run=0 and byte_ready=0.
- A partial word is never written.
REQ-026 SHALL ignore byte_data when byte_valid=0; a byte offered while byte_ready=0 is not consumed.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, enter CNT_HI and set:
- byte_ready=1;
- im_we, cpu_run, err = 0;
- im_addr, im_wdata, words_loaded, index, byte position and idle counter = 0.
REQ-028 SHALL give rst priority over every other event, including a byte accepted or a WRITE in the same cycle; no im_we is issued in the cycle following reset.

Verification
REQ-029 SHALL cover reset: hold rst 2 cycles -> byte_ready=1, im_we=0, cpu_run=0, err=0, words_loaded=0.
REQ-030 SHALL cover a normal load: stream 00 02 20 08 00 05 01 09 50 20 back-to-back -> writes at addr 0 = 20080005 and addr 1 = 01095020, one cycle each; then cpu_run=1, words_loaded=2, byte_ready=0.
REQ-031 SHALL cover an empty program: stream 00 00 -> no im_we, cpu_run=1 on the cycle after the 2nd byte.
REQ-032 SHALL cover oversize: ADDR_W=8, stream 01 01 -> err=1, cpu_run=0, no im_we, further bytes not accepted.
REQ-033 SHALL cover stall and timeout: send count 00 01 with 5-cycle gaps between bytes -> word written normally; a separate run with a gap of TIMEOUT cycles after the 2nd word byte -> err=1, no im_we.
REQ-034 SHALL cover reset mid-load: after 5 bytes of a 2-word frame, pulse rst -> CNT_HI, words_loaded=0, no spurious write; the full frame resent afterwards loads correctly.
